// File: rtl/dp_switch_irq_ctrl.sv
// rtl/dp_switch_irq_ctrl.sv - debounced DIP-switch port with edge capture and level interrupt
module dp_switch_irq_ctrl #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync0;
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] debounced_d;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [2:0]       ctrl;
    logic [CNT_W-1:0] cnt [WIDTH];

    logic             wr;
    logic             wr_edge;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] clr;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign wr_edge      = wr && (address == 2'd1);
    assign unused_wdata = ^writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync0   <= '0;
            sync_in <= '0;
        end else begin
            sync0   <= in_port;
            sync_in <= sync0;
        end
    end

    // The counter only advances while the synchronised level disagrees with the debounced one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounced <= '0;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (ctrl[2]) begin
                    debounced[i] <= sync_in[i];
                    cnt[i]       <= '0;
                end else if (sync_in[i] == debounced[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    debounced[i] <= sync_in[i];
                    cnt[i]       <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign rise = debounced & ~debounced_d;
    assign fall = ~debounced & debounced_d;
    assign set  = (rise & {WIDTH{ctrl[0]}}) | (fall & {WIDTH{ctrl[1]}});
    assign clr  = wr_edge ? writedata[WIDTH-1:0] : '0;

    always_comb begin
        rd_mux = '0;
        if (chipselect) begin
            case (address)
                2'd0:    rd_mux[WIDTH-1:0] = debounced;
                2'd1:    rd_mux[WIDTH-1:0] = edge_capture;
                2'd2:    rd_mux[WIDTH-1:0] = irq_mask;
                default: rd_mux[2:0]       = ctrl;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            debounced_d  <= '0;
            edge_capture <= '0;
            irq_mask     <= '0;
            ctrl         <= 3'b001;
            readdata     <= '0;
            irq          <= 1'b0;
        end else begin
            debounced_d  <= debounced;
            // Set is OR-ed in after the clear so a fresh edge is never lost to a W1C.
            edge_capture <= (edge_capture & ~clr) | set;
            if (wr && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
            if (wr && address == 2'd3) ctrl <= writedata[2:0];
            readdata     <= rd_mux;
            irq          <= |(edge_capture & irq_mask);
        end
    end

endmodule
